// File: rtl/mem_arbiter_pkg.sv
// Shared types for the instruction-fetch / load-store memory arbiter.
package mem_arbiter_pkg;

  // Arbiter FSM: IDLE picks an owner, REQ presents the command, RESP waits for data.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  // Owner of the transaction currently in flight.
  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_LS = 1'b1;

endpackage

// File: rtl/mem_arbiter.sv
// Two-master arbiter (instruction fetch, load/store) in front of a single-port memory.
// One transaction in flight at a time; LS has priority, and IF is forced through
// after STARVE_LIM consecutive LS grants that it had to wait behind.
//
// Handshakes: a requester holds *_req and its command fields stable until it sees
// *_gnt high in the same cycle; the grant is a single-cycle pulse and the command
// is captured on that edge. Toward memory, mem_req and mem_* stay stable until
// mem_gnt is high; exactly one mem_rvalid pulse is expected afterwards and is
// forwarded combinationally as if_rvalid or ls_rvalid. Any mem_rvalid seen outside
// the response phase is dropped.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_LIM = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              if_req,
  input  logic [AW-1:0]                     if_addr,
  output logic                              if_gnt,
  output logic                              if_rvalid,
  output logic [DW-1:0]                     if_rdata,
  input  logic                              ls_req,
  input  logic                              ls_we,
  input  logic [AW-1:0]                     ls_addr,
  input  logic [DW-1:0]                     ls_wdata,
  input  logic [DW/8-1:0]                   ls_wstrb,
  output logic                              ls_gnt,
  output logic                              ls_rvalid,
  output logic [DW-1:0]                     ls_rdata,
  output logic                              mem_req,
  output logic                              mem_we,
  output logic [AW-1:0]                     mem_addr,
  output logic [DW-1:0]                     mem_wdata,
  output logic [DW/8-1:0]                   mem_wstrb,
  input  logic                              mem_gnt,
  input  logic                              mem_rvalid,
  input  logic [DW-1:0]                     mem_rdata,
  output logic [1:0]                        dbg_state,
  output logic [$clog2(STARVE_LIM+1)-1:0]   dbg_starve_cnt
);

  localparam int SCW = $clog2(STARVE_LIM + 1);

  state_e             state_q, state_d;
  logic               owner_q;
  logic               we_q;
  logic [AW-1:0]      addr_q;
  logic [DW-1:0]      wdata_q;
  logic [DW/8-1:0]    wstrb_q;
  logic [SCW-1:0]     starve_q, starve_d;
  logic               sel_if, sel_ls;

  assign dbg_state      = state_q;
  assign dbg_starve_cnt = starve_q;

  // Owner selection in IDLE: LS first unless IF has waited out its starvation budget.
  always_comb begin
    sel_if = 1'b0;
    sel_ls = 1'b0;
    if (rst_n && state_q == IDLE) begin
      if (if_req && (!ls_req || starve_q == SCW'(STARVE_LIM))) begin
        sel_if = 1'b1;
      end else if (ls_req) begin
        sel_ls = 1'b1;
      end
    end
  end

  // Starvation counter: counts LS grants that IF sat behind, cleared once IF is served or idle.
  always_comb begin
    starve_d = starve_q;
    if (state_q == IDLE) begin
      if (sel_if || !if_req) begin
        starve_d = '0;
      end else if (sel_ls && starve_q != SCW'(STARVE_LIM)) begin
        starve_d = starve_q + SCW'(1);
      end
    end
  end

  // Next state and all outputs; everything is held at zero while reset is asserted.
  always_comb begin
    state_d   = state_q;
    if_gnt    = 1'b0;
    ls_gnt    = 1'b0;
    if_rvalid = 1'b0;
    ls_rvalid = 1'b0;
    if_rdata  = '0;
    ls_rdata  = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    if (rst_n) begin
      case (state_q)
        IDLE: begin
          if_gnt = sel_if;
          ls_gnt = sel_ls;
          if (sel_if || sel_ls) state_d = REQ;
        end
        REQ: begin
          mem_req   = 1'b1;
          mem_we    = we_q;
          mem_addr  = addr_q;
          mem_wdata = wdata_q;
          mem_wstrb = wstrb_q;
          if (mem_gnt) state_d = RESP;
        end
        RESP: begin
          if (mem_rvalid) begin
            if (owner_q == OWN_IF) begin
              if_rvalid = 1'b1;
              if_rdata  = mem_rdata;
            end else begin
              ls_rvalid = 1'b1;
              ls_rdata  = mem_rdata;
            end
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, starvation count and the captured command of the granted owner.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      starve_q <= '0;
      owner_q  <= OWN_IF;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      if (sel_if) begin
        owner_q <= OWN_IF;
        we_q    <= 1'b0;
        addr_q  <= if_addr;
        wdata_q <= '0;
        wstrb_q <= '0;
      end else if (sel_ls) begin
        owner_q <= OWN_LS;
        we_q    <= ls_we;
        addr_q  <= ls_addr;
        wdata_q <= ls_wdata;
        wstrb_q <= ls_we ? ls_wstrb : '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a transaction-level reference model
// checked every cycle, plus literal expectations at key cycles.
module tb_mem_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LIM = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic            if_req;
  logic [AW-1:0]   if_addr;
  logic            if_gnt, if_rvalid;
  logic [DW-1:0]   if_rdata;
  logic            ls_req, ls_we;
  logic [AW-1:0]   ls_addr;
  logic [DW-1:0]   ls_wdata;
  logic [DW/8-1:0] ls_wstrb;
  logic            ls_gnt, ls_rvalid;
  logic [DW-1:0]   ls_rdata;
  logic            mem_req, mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW/8-1:0] mem_wstrb;
  logic            mem_gnt, mem_rvalid;
  logic [DW-1:0]   mem_rdata;
  logic [1:0]      dbg_state;
  logic [2:0]      dbg_starve_cnt;

  mem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIM(LIM)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_wstrb(ls_wstrb), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .dbg_state(dbg_state), .dbg_starve_cnt(dbg_starve_cnt)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  // One record for the transaction in flight: who owns it, whether memory has
  // accepted it yet, and the command captured at grant time.
  bit              m_busy   = 1'b0;
  bit              m_issued = 1'b0;
  bit              m_is_ls  = 1'b0;
  logic            m_we     = 1'b0;
  logic [AW-1:0]   m_addr   = '0;
  logic [DW-1:0]   m_wdata  = '0;
  logic [DW/8-1:0] m_wstrb  = '0;
  int              m_starve = 0;

  function automatic bit pick_if();
    return if_req && (!ls_req || m_starve == LIM);
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_issued = 1'b0; m_starve = 0;
    end else if (!m_busy) begin
      if (if_req || ls_req) begin
        m_busy = 1'b1; m_issued = 1'b0;
        if (pick_if()) begin
          m_is_ls = 1'b0; m_we = 1'b0; m_addr = if_addr; m_wdata = '0; m_wstrb = '0;
          m_starve = 0;
        end else begin
          m_is_ls = 1'b1; m_we = ls_we; m_addr = ls_addr; m_wdata = ls_wdata;
          m_wstrb = ls_we ? ls_wstrb : '0;
          if (if_req && m_starve < LIM) m_starve = m_starve + 1;
        end
      end
      if (!if_req) m_starve = 0;
    end else if (!m_issued) begin
      if (mem_gnt) m_issued = 1'b1;
    end else if (mem_rvalid) begin
      m_busy = 1'b0;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  bit e_ifg, e_lsg, e_mreq, e_ifv, e_lsv;
  always @(negedge clk) begin
    if (chk_en) begin
      e_ifg  = rst_n && !m_busy && pick_if();
      e_lsg  = rst_n && !m_busy && ls_req && !pick_if();
      e_mreq = rst_n && m_busy && !m_issued;
      e_ifv  = rst_n && m_busy && m_issued && mem_rvalid && !m_is_ls;
      e_lsv  = rst_n && m_busy && m_issued && mem_rvalid && m_is_ls;
      chk("cmp_if_gnt", if_gnt, e_ifg);
      chk("cmp_ls_gnt", ls_gnt, e_lsg);
      chk("cmp_mem_req", mem_req, e_mreq);
      chk("cmp_if_rvalid", if_rvalid, e_ifv);
      chk("cmp_ls_rvalid", ls_rvalid, e_lsv);
      chk("cmp_state", dbg_state, !m_busy ? 0 : (m_issued ? 2 : 1));
      chk("cmp_starve", dbg_starve_cnt, m_starve);
      if (e_mreq) begin
        chk("cmp_mem_we", mem_we, m_we);
        chk("cmp_mem_addr", mem_addr, m_addr);
        chk("cmp_mem_wstrb", mem_wstrb, m_wstrb);
        if (m_we) chk("cmp_mem_wdata", mem_wdata, m_wdata);
      end
      if (!rst_n) begin
        chk("cmp_rst_mem_fields", {mem_we, mem_addr, mem_wdata, mem_wstrb}, 0);
      end
      if (e_ifv) chk("cmp_if_rdata", if_rdata, mem_rdata);
      if (e_lsv && !m_we) chk("cmp_ls_rdata", ls_rdata, mem_rdata);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called at the start of the REQ cycle: stall gw cycles, accept, then respond.
  task automatic serve(input int gw, input logic [DW-1:0] rd);
    for (int i = 0; i < gw; i++) begin
      mem_gnt = 1'b0;
      tick();
    end
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = rd;
    tick();
    mem_rvalid = 1'b0; mem_rdata = '0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst_n = 1'b0;
    if_req = 0; if_addr = '0;
    ls_req = 0; ls_we = 0; ls_addr = '0; ls_wdata = '0; ls_wstrb = '0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
    chk_en = 1'b1;

    // Reset state
    repeat (2) tick();
    @(negedge clk);
    chk("rst_state", dbg_state, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_starve", dbg_starve_cnt, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single fetch: grant, memory command, data
    if_req = 1; if_addr = 32'h100;
    @(negedge clk);
    chk("f_if_gnt", if_gnt, 1);
    chk("f_mem_req_c1", mem_req, 0);
    tick();
    if_req = 0; if_addr = '0; mem_gnt = 1;
    @(negedge clk);
    chk("f_mem_req_c2", mem_req, 1);
    chk("f_mem_addr", mem_addr, 32'h100);
    chk("f_mem_we", mem_we, 0);
    tick();
    mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("f_if_rvalid", if_rvalid, 1);
    chk("f_if_rdata", if_rdata, 32'hDEADBEEF);
    chk("f_ls_rvalid", ls_rvalid, 0);
    tick();
    mem_rvalid = 0; mem_rdata = '0;

    // Simultaneous store and fetch: store first, fetch in the next IDLE
    if_req = 1; if_addr = 32'h104;
    ls_req = 1; ls_we = 1; ls_addr = 32'h200; ls_wdata = 32'h12345678; ls_wstrb = 4'hF;
    @(negedge clk);
    chk("s_ls_gnt", ls_gnt, 1);
    chk("s_if_gnt", if_gnt, 0);
    tick();
    ls_req = 0; ls_we = 0; ls_addr = '0; ls_wdata = '0; ls_wstrb = '0; mem_gnt = 1;
    @(negedge clk);
    chk("s_mem_we", mem_we, 1);
    chk("s_mem_addr", mem_addr, 32'h200);
    chk("s_mem_wdata", mem_wdata, 32'h12345678);
    chk("s_mem_wstrb", mem_wstrb, 4'hF);
    chk("s_if_gnt_in_req", if_gnt, 0);
    tick();
    mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h55;
    @(negedge clk);
    chk("s_ls_rvalid", ls_rvalid, 1);
    chk("s_if_rvalid", if_rvalid, 0);
    tick();
    mem_rvalid = 0; mem_rdata = '0;
    @(negedge clk);
    chk("s_if_gnt_next_idle", if_gnt, 1);
    tick();
    if_req = 0;
    serve(0, 32'hCAFE0001);

    // Load: strobes ignored, data returned on ls_rdata
    ls_req = 1; ls_we = 0; ls_addr = 32'h400; ls_wdata = 32'hFFFF0000; ls_wstrb = 4'hA;
    @(negedge clk);
    chk("l_ls_gnt", ls_gnt, 1);
    tick();
    ls_req = 0; ls_wstrb = '0; mem_gnt = 1;
    @(negedge clk);
    chk("l_mem_wstrb", mem_wstrb, 0);
    chk("l_mem_we", mem_we, 0);
    tick();
    mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hA5A50F0F;
    @(negedge clk);
    chk("l_ls_rdata", ls_rdata, 32'hA5A50F0F);
    tick();
    mem_rvalid = 0; mem_rdata = '0;

    // Starvation: IF held behind a stream of stores
    if_req = 1; if_addr = 32'h500; ls_req = 1; ls_we = 1; ls_wstrb = 4'h3;
    for (int i = 0; i < LIM; i++) begin
      ls_addr = 32'h300 + 32'(i * 4); ls_wdata = 32'(i);
      @(negedge clk);
      chk("st_ls_gnt", ls_gnt, 1);
      chk("st_if_gnt", if_gnt, 0);
      tick();
      serve(0, '0);
    end
    @(negedge clk);
    chk("st_if_wins", if_gnt, 1);
    chk("st_ls_loses", ls_gnt, 0);
    chk("st_cnt_at_lim", dbg_starve_cnt, LIM);
    tick();
    if_req = 0;
    serve(0, 32'h11112222);
    @(negedge clk);
    chk("st_ls_after_if", ls_gnt, 1);
    chk("st_cnt_cleared", dbg_starve_cnt, 0);
    tick();
    ls_req = 0; ls_we = 0; ls_wstrb = '0;
    serve(0, '0);

    // Memory stall: command stable, no new grants while stalled
    if_req = 1; if_addr = 32'h600;
    @(negedge clk);
    chk("ms_if_gnt", if_gnt, 1);
    tick();
    if_req = 0; if_addr = 32'h7FC; ls_req = 1; ls_we = 0; ls_addr = 32'h800;
    for (int i = 0; i < 5; i++) begin
      mem_gnt = 0;
      @(negedge clk);
      chk("ms_mem_req", mem_req, 1);
      chk("ms_mem_addr", mem_addr, 32'h600);
      chk("ms_no_ls_gnt", ls_gnt, 0);
      tick();
    end
    mem_gnt = 1;
    tick();
    mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h600D;
    @(negedge clk);
    chk("ms_if_rdata", if_rdata, 32'h600D);
    tick();
    mem_rvalid = 0; mem_rdata = '0;
    @(negedge clk);
    chk("ms_ls_gnt_after", ls_gnt, 1);
    tick();
    ls_req = 0;
    serve(1, 32'h0BAD0001);

    // Reset during RESP; late response must be dropped
    if_req = 1; if_addr = 32'h900;
    tick();
    if_req = 0; mem_gnt = 1;
    tick();
    mem_gnt = 0; rst_n = 0; mem_rvalid = 1; mem_rdata = 32'h77;
    @(negedge clk);
    chk("rr_if_rvalid_in_rst", if_rvalid, 0);
    chk("rr_if_rdata_in_rst", if_rdata, 0);
    tick();
    mem_rvalid = 0;
    tick();
    rst_n = 1; mem_rvalid = 1; mem_rdata = 32'h88;
    @(negedge clk);
    chk("rr_state_idle", dbg_state, 0);
    chk("rr_if_rvalid_late", if_rvalid, 0);
    chk("rr_ls_rvalid_late", ls_rvalid, 0);
    chk("rr_mem_req", mem_req, 0);
    tick();
    mem_rvalid = 0; mem_rdata = '0;

    // Spurious response in IDLE
    tick();
    mem_rvalid = 1; mem_rdata = 32'h99;
    @(negedge clk);
    chk("sp_if_rvalid", if_rvalid, 0);
    chk("sp_ls_rvalid", ls_rvalid, 0);
    tick();
    mem_rvalid = 0; mem_rdata = '0;
    @(negedge clk);
    chk("sp_state", dbg_state, 0);
    tick();

    repeat (2) tick();
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    n_errors++;
    $display("FAIL timeout actual=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 32: address width.
REQ-002 SHALL have parameter DW, default 32: data width; byte strobes are DW/8 bits.
REQ-003 SHALL have parameter STARVE_LIM, default 4: number of back-to-back LS grants allowed while IF is waiting.
REQ-004 clk  in  1  single clock; all logic rising-edge.
REQ-005 rst_n  in  1  synchronous, active-low reset.
REQ-006 if_req  in  1  instruction-fetch read request; held until if_gnt.
REQ-007 if_addr  in  AW  fetch address.
REQ-008 if_gnt  out  1  fetch request accepted this cycle.
REQ-009 if_rvalid  out  1  fetch data valid, one-cycle pulse.
REQ-010 if_rdata  out  DW  fetch data.
REQ-011 ls_req  in  1  load/store request; held until ls_gnt.
REQ-012 ls_we  in  1  1 = store, 0 = load.
REQ-013 ls_addr  in  AW  load/store address.
REQ-014 ls_wdata  in  DW  store data.
REQ-015 ls_wstrb  in  DW/8  store byte enables.
REQ-016 ls_gnt  out  1  load/store request accepted.
REQ-017 ls_rvalid  out  1  load data valid or store acknowledge, one-cycle pulse.
REQ-018 ls_rdata  out  DW  load data; don't-care on store acknowledge.
REQ-019 mem_req  out  1  request to the single-port memory.
REQ-020 mem_we, mem_addr, mem_wdata, mem_wstrb  out  1/AW/DW/DW/8  memory command fields.
REQ-021 mem_gnt  in  1  memory accepts the command this cycle.
REQ-022 mem_rvalid  in  1  memory response pulse.
REQ-023 mem_rdata  in  DW  memory read data.

Function
REQ-024 SHALL implement FSM states IDLE, REQ, RESP.
REQ-025 IDLE: if any request is pending, SHALL select an owner, latch that owner's command into internal registers, and go to REQ; otherwise SHALL stay in IDLE.
REQ-026 Selection: LS SHALL win over IF, except IF SHALL win when starve_cnt == STARVE_LIM and if_req = 1.
REQ-027 The owner's if_gnt/ls_gnt SHALL pulse for exactly one cycle, the IDLE->REQ transition cycle; the requester may change its command fields from the next cycle.
REQ-028 REQ: mem_req SHALL be 1 with mem_* driven from the latched registers; on mem_gnt = 1 the FSM SHALL go to RESP.
REQ-029 RESP: mem_req SHALL be 0; on mem_rvalid the FSM SHALL route it combinationally in the same cycle (if_rvalid/if_rdata or ls_rvalid/ls_rdata per the latched owner), then go to IDLE.
REQ-030 At most one memory transaction SHALL be outstanding; minimum occupancy is 3 cycles per transaction (IDLE, REQ, RESP with mem_gnt and mem_rvalid each arriving in their first eligible cycle).
REQ-031 starve_cnt (width clog2(STARVE_LIM+1)) SHALL increment, saturating, when LS is granted while if_req = 1, and SHALL clear on any IF grant or when if_req = 0 in IDLE.
REQ-032 mem_rvalid outside RESP SHALL be ignored, with no rvalid forwarded.
REQ-033 Requests seen in REQ/RESP SHALL NOT be granted until the next IDLE.
REQ-034 mem_we SHALL be 0 for IF-owned transactions; mem_wstrb SHALL be 0 for loads and IF.
REQ-035 Simultaneous if_req and ls_req in IDLE SHALL be resolved per REQ-026 in that same cycle.

Reset
REQ-036 While rst_n = 0 at a clock edge, the FSM SHALL go to IDLE and starve_cnt and the latched command SHALL clear to 0.
REQ-037 During reset, if_gnt, ls_gnt, if_rvalid, ls_rvalid and mem_req SHALL be 0, and mem_* fields SHALL be 0.
REQ-038 A reset in REQ or RESP SHALL abandon the transaction, and any late mem_rvalid after reset SHALL be dropped per REQ-032.

Structure
REQ-039 A shared package SHALL hold the FSM state enum (IDLE=2'd0, REQ=2'd1, RESP=2'd2) and the owner encoding (OWN_IF=1'b0, OWN_LS=1'b1).
REQ-040 The block SHALL be a single module with no sub-modules; priority/starvation logic SHALL be an always_comb block inside it.

Verification
REQ-041 if_req only, addr 0x100, mem_gnt immediate, mem_rvalid next cycle with 0xDEADBEEF -> if_gnt in cycle 1, mem_req in cycle 2, if_rvalid with if_rdata = 0xDEADBEEF in cycle 3.
REQ-042 if_req and ls_req (store, addr 0x200, wdata 0x12345678, wstrb 4'hF) in the same cycle -> ls_gnt first, mem_we = 1, ls_rvalid ack, then if_gnt in the following IDLE.
REQ-043 if_req held while ls_req is continuously re-asserted, STARVE_LIM = 4 -> exactly 4 LS grants, then if_gnt, with starve_cnt cleared to 0.
REQ-044 mem_gnt held low 5 cycles in REQ -> mem_req and mem_addr stable for all 5 cycles, and no new grant is issued.
REQ-045 rst_n asserted low in RESP, then mem_rvalid arrives after reset -> FSM in IDLE, no if_rvalid/ls_rvalid pulse, all outputs 0.
REQ-046 Spurious mem_rvalid in IDLE -> no rvalid output and no state change.
